// File: rtl/jtvigil_snd_ctrl.sv
// Sound CPU glue: sound latch, IM0 interrupt vector, sample-ROM fetcher with a one-byte
// prefetch buffer, DAC register and an optional periodic NMI.
// Build option: define JTVIGIL_SNDNMI_EN to build the NMI counter; otherwise nmi_n is tied high.
// SAW must be in 9..16: the high address byte supplies rom_addr[SAW-1:8] from snd_dout[SAW-9:0].
module jtvigil_snd_ctrl #(
  parameter int unsigned NMI_DIV = 128,
  parameter int unsigned SAW     = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           latch_wr,
  input  logic [7:0]     main_dout,
  output logic [7:0]     snd_latch,
  input  logic           ack_wr,
  input  logic           ym_irq_n,
  output logic           int_n,
  output logic [7:0]     int_vec,
  input  logic           addr_lo_wr,
  input  logic           addr_hi_wr,
  input  logic           dac_wr,
  input  logic [7:0]     snd_dout,
  input  logic           smp_rd,
  output logic [7:0]     smp_dout,
  output logic           smp_busy,
  output logic [SAW-1:0] rom_addr,
  output logic           rom_cs,
  input  logic [7:0]     rom_data,
  input  logic           rom_ok,
  output logic [7:0]     dac,
  input  logic           nmi_cen,
  output logic           nmi_n
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid} fetch_e;

  logic           r_latch_wr_l, r_ack_wr_l, r_lo_wr_l, r_hi_wr_l, r_dac_wr_l, r_smp_rd_l;
  logic           w_latch_rise, w_ack_rise, w_lo_rise, w_hi_rise, w_dac_rise, w_rd_rise;
  logic           r_latch_pend;
  logic           w_ym_pend;
  logic [7:0]     r_snd_latch, r_int_vec, r_dac, r_smp_dout;
  logic           r_int_n;
  logic [SAW-1:0] r_rom_addr;
  logic           r_ok_q;
  fetch_e         r_st, w_st_nxt;
  logic           w_addr_wr, w_rd_inc, w_capture;

  assign w_latch_rise = latch_wr   & ~r_latch_wr_l;
  assign w_ack_rise   = ack_wr     & ~r_ack_wr_l;
  assign w_lo_rise    = addr_lo_wr & ~r_lo_wr_l;
  assign w_hi_rise    = addr_hi_wr & ~r_hi_wr_l;
  assign w_dac_rise   = dac_wr     & ~r_dac_wr_l;
  assign w_rd_rise    = smp_rd     & ~r_smp_rd_l;
  assign w_ym_pend    = ~ym_irq_n;

  // Strobe history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch_wr_l <= 1'b0;
      r_ack_wr_l   <= 1'b0;
      r_lo_wr_l    <= 1'b0;
      r_hi_wr_l    <= 1'b0;
      r_dac_wr_l   <= 1'b0;
      r_smp_rd_l   <= 1'b0;
    end else begin
      r_latch_wr_l <= latch_wr;
      r_ack_wr_l   <= ack_wr;
      r_lo_wr_l    <= addr_lo_wr;
      r_hi_wr_l    <= addr_hi_wr;
      r_dac_wr_l   <= dac_wr;
      r_smp_rd_l   <= smp_rd;
    end
  end

  // Sound latch, pending flag and registered interrupt request/vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snd_latch  <= 8'h00;
      r_latch_pend <= 1'b0;
      r_int_n      <= 1'b1;
      r_int_vec    <= 8'hFF;
    end else begin
      if (w_latch_rise) begin
        r_snd_latch  <= main_dout;
        r_latch_pend <= 1'b1;      // a new write wins over a simultaneous ack
      end else if (w_ack_rise) begin
        r_latch_pend <= 1'b0;
      end
      r_int_n   <= ~(r_latch_pend | w_ym_pend);
      r_int_vec <= 8'hFF & ~{2'b00, r_latch_pend, w_ym_pend, 4'h0};
    end
  end

  // DAC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dac <= 8'h80;
    end else if (w_dac_rise) begin
      r_dac <= snd_dout;
    end
  end

  assign w_addr_wr = w_lo_rise | w_hi_rise;
  assign w_rd_inc  = (r_st == StValid) & w_rd_rise & ~w_addr_wr;
  // rom_ok must be seen on two edges after the address settled, so a stale ok is never taken
  assign w_capture = (r_st == StFetch) & ~w_addr_wr & rom_ok & r_ok_q;

  // Fetch FSM next state; an address write always (re)starts a fetch
  always_comb begin
    w_st_nxt = r_st;
    if (w_addr_wr) begin
      w_st_nxt = StFetch;
    end else begin
      unique case (r_st)
        StFetch: if (w_capture) w_st_nxt = StValid;
        StValid: if (w_rd_inc)  w_st_nxt = StFetch;
        default: w_st_nxt = r_st;
      endcase
    end
  end

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= StIdle;
    else     r_st <= w_st_nxt;
  end

  // Sample address counter, rom_ok qualifier and prefetch buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_ok_q     <= 1'b0;
      r_smp_dout <= 8'hFF;
    end else begin
      if (w_addr_wr) begin
        if (w_lo_rise) r_rom_addr[7:0]     <= snd_dout;
        if (w_hi_rise) r_rom_addr[SAW-1:8] <= snd_dout[SAW-9:0];
      end else if (w_rd_inc) begin
        r_rom_addr <= r_rom_addr + {{(SAW-1){1'b0}}, 1'b1};
      end
      r_ok_q <= (w_addr_wr | w_rd_inc) ? 1'b0 : rom_ok;
      if (w_capture) r_smp_dout <= rom_data;
    end
  end

`ifdef JTVIGIL_SNDNMI_EN
  localparam int unsigned CW = (NMI_DIV > 2) ? $clog2(NMI_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(NMI_DIV - 1);

  logic [CW-1:0] r_nmi_cnt;
  logic          r_nmi_n;

  // NMI timebase: one-clock low pulse each time the counter wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nmi_cnt <= '0;
      r_nmi_n   <= 1'b1;
    end else begin
      r_nmi_n <= 1'b1;
      if (nmi_cen) begin
        if (r_nmi_cnt == CntLast) begin
          r_nmi_cnt <= '0;
          r_nmi_n   <= 1'b0;
        end else begin
          r_nmi_cnt <= r_nmi_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign nmi_n = r_nmi_n;
`else
  logic w_unused_nmi;
  assign w_unused_nmi = nmi_cen ^ NMI_DIV[0];
  assign nmi_n        = 1'b1;
`endif

  assign snd_latch = r_snd_latch;
  assign int_n     = r_int_n;
  assign int_vec   = r_int_vec;
  assign dac       = r_dac;
  assign rom_addr  = r_rom_addr;
  assign smp_dout  = r_smp_dout;
  assign rom_cs    = (r_st == StFetch);
  assign smp_busy  = (r_st != StValid);

endmodule

// File: tb/tb_jtvigil_snd_ctrl.sv
// Self-checking bench for jtvigil_snd_ctrl: table-driven latch/IRQ/DAC vectors plus
// hand-written sample-fetch, reset and NMI sequences.
module tb_jtvigil_snd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch_wr, ack_wr, ym_irq_n, addr_lo_wr, addr_hi_wr, dac_wr, smp_rd;
  logic        rom_ok, nmi_cen;
  logic [7:0]  main_dout, snd_dout, rom_data;
  logic [7:0]  snd_latch, int_vec, smp_dout, dac;
  logic        int_n, smp_busy, rom_cs, nmi_n;
  logic [15:0] rom_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       latch_wr;
    logic       ack_wr;
    logic       ym_irq_n;
    logic [7:0] main_dout;
    logic       dac_wr;
    logic [7:0] snd_dout;
    logic [7:0] exp_latch;
    logic       exp_int_n;
    logic [7:0] exp_vec;
    logic [7:0] exp_dac;
  } vec_t;

  vec_t vecs[21];

  jtvigil_snd_ctrl #(.NMI_DIV(4), .SAW(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .latch_wr   (latch_wr),
    .main_dout  (main_dout),
    .snd_latch  (snd_latch),
    .ack_wr     (ack_wr),
    .ym_irq_n   (ym_irq_n),
    .int_n      (int_n),
    .int_vec    (int_vec),
    .addr_lo_wr (addr_lo_wr),
    .addr_hi_wr (addr_hi_wr),
    .dac_wr     (dac_wr),
    .snd_dout   (snd_dout),
    .smp_rd     (smp_rd),
    .smp_dout   (smp_dout),
    .smp_busy   (smp_busy),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .dac        (dac),
    .nmi_cen    (nmi_cen),
    .nmi_n      (nmi_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the prefetch buffer to become valid
  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!smp_busy) break;
      tick();
    end
    chk(name, smp_busy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_snd_latch"}, snd_latch, 8'h00);
    chk({tag, "_int_n"},     int_n,     1'b1);
    chk({tag, "_int_vec"},   int_vec,   8'hFF);
    chk({tag, "_rom_addr"},  rom_addr,  16'h0000);
    chk({tag, "_rom_cs"},    rom_cs,    1'b0);
    chk({tag, "_smp_dout"},  smp_dout,  8'hFF);
    chk({tag, "_smp_busy"},  smp_busy,  1'b1);
    chk({tag, "_dac"},       dac,       8'h80);
    chk({tag, "_nmi_n"},     nmi_n,     1'b1);
  endtask

  initial begin
    // latch_wr, ack_wr, ym_irq_n, main_dout, dac_wr, snd_dout | latch, int_n, vec, dac
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h5A, 1'b1, 8'hFF, 8'h80};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 8'h5A, 1'b0, 8'hDF, 8'h80};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b0, 8'hDF, 8'h80};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b0, 8'hDF, 8'h80};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b1, 8'hFF, 8'h80};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b1, 8'hFF, 8'h80};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 1'b1, 8'hFF, 8'h80};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 8'hCF, 8'h80};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 8'hCF, 8'h80};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b0, 8'hEF, 8'h80};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1, 8'hFF, 8'h80};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 8'h00, 8'h96, 1'b1, 8'hFF, 8'h80};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h96, 1'b0, 8'hDF, 8'h80};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h96, 1'b0, 8'hDF, 8'h80};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h96, 1'b1, 8'hFF, 8'h80};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hC3, 8'h96, 1'b1, 8'hFF, 8'hC3};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h44, 8'h96, 1'b1, 8'hFF, 8'hC3};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h44, 8'h96, 1'b1, 8'hFF, 8'hC3};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h07, 8'h96, 1'b1, 8'hFF, 8'h07};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 8'h96, 1'b0, 8'hEF, 8'h07};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h07, 8'h96, 1'b1, 8'hFF, 8'h07};

    rst = 1'b1;
    latch_wr = 1'b0; ack_wr = 1'b0; ym_irq_n = 1'b1; addr_lo_wr = 1'b0; addr_hi_wr = 1'b0;
    dac_wr = 1'b0; smp_rd = 1'b0; rom_ok = 1'b0; nmi_cen = 1'b0;
    main_dout = 8'h00; snd_dout = 8'h00; rom_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");

    // Latch / interrupt vector / DAC table
    for (int i = 0; i < 21; i++) begin
      latch_wr  = vecs[i].latch_wr;
      ack_wr    = vecs[i].ack_wr;
      ym_irq_n  = vecs[i].ym_irq_n;
      main_dout = vecs[i].main_dout;
      dac_wr    = vecs[i].dac_wr;
      snd_dout  = vecs[i].snd_dout;
      tick();
      chk($sformatf("vec%0d_snd_latch", i), snd_latch, vecs[i].exp_latch);
      chk($sformatf("vec%0d_int_n", i),     int_n,     vecs[i].exp_int_n);
      chk($sformatf("vec%0d_int_vec", i),   int_vec,   vecs[i].exp_vec);
      chk($sformatf("vec%0d_dac", i),       dac,       vecs[i].exp_dac);
    end
    latch_wr = 1'b0; ack_wr = 1'b0; ym_irq_n = 1'b1; dac_wr = 1'b0;

    // Fetch at 0x1234, rom_ok arrives after 3 clocks with AB
    snd_dout = 8'h12; addr_hi_wr = 1'b1; tick();
    addr_hi_wr = 1'b0; snd_dout = 8'h34; addr_lo_wr = 1'b1; tick();
    addr_lo_wr = 1'b0;
    chk("f1_rom_addr", rom_addr, 16'h1234);
    chk("f1_rom_cs", rom_cs, 1'b1);
    chk("f1_busy", smp_busy, 1'b1);
    tick(); tick(); tick();
    rom_ok = 1'b1; rom_data = 8'hAB;
    tick();
    chk("f1_busy_qual", smp_busy, 1'b1);
    wait_valid("f1_busy_timeout");
    chk("f1_smp_dout", smp_dout, 8'hAB);
    chk("f1_rom_cs_off", rom_cs, 1'b0);
    rom_ok = 1'b0; rom_data = 8'h00;
    smp_rd = 1'b1; tick();
    chk("f1_rd_addr", rom_addr, 16'h1235);
    chk("f1_rd_busy", smp_busy, 1'b1);
    chk("f1_rd_cs", rom_cs, 1'b1);
    chk("f1_rd_hold", smp_dout, 8'hAB);
    smp_rd = 1'b0; tick();
    smp_rd = 1'b1; tick();
    chk("f1_rd_in_fetch", rom_addr, 16'h1235);
    rom_ok = 1'b1; rom_data = 8'h5E;
    wait_valid("f2_busy_timeout");
    chk("f2_smp_dout", smp_dout, 8'h5E);
    tick();
    chk("f2_held_rd", rom_addr, 16'h1235);
    smp_rd = 1'b0; rom_ok = 1'b0;

    // Wrap at 0xFFFF, then a stale rom_ok around an address write
    snd_dout = 8'hFF; addr_hi_wr = 1'b1; tick();
    addr_hi_wr = 1'b0; addr_lo_wr = 1'b1; tick();
    addr_lo_wr = 1'b0;
    chk("w_rom_addr", rom_addr, 16'hFFFF);
    tick();
    rom_ok = 1'b1; rom_data = 8'h01;
    wait_valid("w_busy_timeout");
    chk("w_smp_dout", smp_dout, 8'h01);
    rom_ok = 1'b0;
    smp_rd = 1'b1; tick();
    smp_rd = 1'b0;
    chk("w_wrap_addr", rom_addr, 16'h0000);
    chk("w_wrap_busy", smp_busy, 1'b1);
    tick(); tick();
    rom_ok = 1'b1; rom_data = 8'hEE; tick();
    chk("s_first_ok", smp_busy, 1'b1);
    snd_dout = 8'h40; addr_lo_wr = 1'b1; tick();
    addr_lo_wr = 1'b0; rom_ok = 1'b0;
    chk("s_rom_addr", rom_addr, 16'h0040);
    chk("s_busy", smp_busy, 1'b1);
    chk("s_no_stale", smp_dout, 8'h01);
    tick(); tick(); tick();
    chk("s_still_busy", smp_busy, 1'b1);
    rom_ok = 1'b1; rom_data = 8'h77;
    wait_valid("s_busy_timeout");
    chk("s_smp_dout", smp_dout, 8'h77);
    rom_ok = 1'b0;

    // Asynchronous reset in the middle of a pending latch and fetch
    snd_dout = 8'hC3; dac_wr = 1'b1; tick();
    dac_wr = 1'b0;
    chk("r_dac_pre", dac, 8'hC3);
    main_dout = 8'hA5; latch_wr = 1'b1; tick();
    latch_wr = 1'b0; tick();
    chk("r_int_pre", int_n, 1'b0);
    snd_dout = 8'h10; addr_lo_wr = 1'b1; tick();
    addr_lo_wr = 1'b0;
    chk("r_cs_pre", rom_cs, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // NMI timebase with nmi_cen every clock
    nmi_cen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
`ifdef JTVIGIL_SNDNMI_EN
      chk($sformatf("nmi_t%0d", i), nmi_n, (i % 4 == 3) ? 1'b0 : 1'b1);
`else
      chk($sformatf("nmi_t%0d", i), nmi_n, 1'b1);
`endif
    end
    nmi_cen = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
